// File: rtl/conv_sched_pkg.sv
// Shared types and geometry for the conv2d scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    LOAD,
    READY,
    RUN,
    COMMIT,
    DONE
  } state_t;

  localparam int IMG_DIM = 8;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int N_TAPS  = 9;
  localparam int N_FILT  = 2;
  localparam int N_POS   = 36;
  localparam int WADDR_W = 5;
  localparam int ROW_W   = $clog2(IMG_DIM);
  localparam int POS_W   = 3;
  localparam int TAP_W   = $clog2(N_TAPS);
  localparam int FILT_W  = (N_FILT > 1) ? $clog2(N_FILT) : 1;

endpackage

// File: rtl/conv_scheduler_if.sv
// Load / tap / commit signal bundle between the pins, the scheduler and the MAC stage.
interface conv_scheduler_if;
  import conv_sched_pkg::*;

  logic               abort;
  logic               load_valid;
  logic [IMG_DIM-1:0] load_row;
  logic               load_ready;
  logic               start;
  logic               busy;
  logic               tap_valid;
  logic               tap_pixel;
  logic [WADDR_W-1:0] weight_addr;
  logic [FILT_W-1:0]  filt_idx;
  logic               acc_first;
  logic               acc_last;
  logic               pos_valid;
  logic               pos_ready;
  logic [POS_W-1:0]   pos_x;
  logic [POS_W-1:0]   pos_y;
  logic               done;

  modport master (
    output abort, load_valid, load_row, start, pos_ready,
    input  load_ready, busy, tap_valid, tap_pixel, weight_addr, filt_idx,
           acc_first, acc_last, pos_valid, pos_x, pos_y, done
  );

  modport slave (
    input  abort, load_valid, load_row, start, pos_ready,
    output load_ready, busy, tap_valid, tap_pixel, weight_addr, filt_idx,
           acc_first, acc_last, pos_valid, pos_x, pos_y, done
  );

endinterface

// File: rtl/conv_img_buf.sv
// Binary image store: one row written per beat, single pixel read by (x,y).
module conv_img_buf
  import conv_sched_pkg::*;
#(
  parameter int DIM = IMG_DIM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [$clog2(DIM)-1:0] wr_addr,
  input  logic [DIM-1:0]         wr_data,
  input  logic [$clog2(DIM)-1:0] rd_x,
  input  logic [$clog2(DIM)-1:0] rd_y,
  output logic                   pixel
);

  logic [DIM-1:0] rows [DIM];

  // Row write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIM; i++) rows[i] <= '0;
    end else if (wr_en) begin
      rows[wr_addr] <= wr_data;
    end
  end

  assign pixel = rows[rd_y][rd_x];

endmodule

// File: rtl/conv_scheduler.sv
// Load/run/commit sequencer feeding the conv MAC datapath one tap per cycle.
module conv_scheduler #(
  parameter int IMG_DIM = 8,
  parameter int K_DIM   = 3,
  parameter int N_FILT  = 2
) (
  input logic             clk,
  input logic             rst_n,
  conv_scheduler_if.slave bus
);
  import conv_sched_pkg::*;

  localparam int ROW_BITS = $clog2(IMG_DIM);
  localparam int OUT_LAST = IMG_DIM - K_DIM;
  localparam int TAP_LAST = K_DIM * K_DIM - 1;

  state_t              state;
  state_t              state_nx;
  logic [ROW_BITS-1:0] row_cnt;
  logic [TAP_W-1:0]    tap_cnt;
  logic [FILT_W-1:0]   filt_cnt;
  logic [POS_W-1:0]    pos_x_q;
  logic [POS_W-1:0]    pos_y_q;
  logic [ROW_BITS-1:0] rd_x;
  logic [ROW_BITS-1:0] rd_y;
  logic                pixel;
  logic                load_fire;
  logic                commit_fire;
  logic                last_row;
  logic                last_tap;
  logic                last_filt;
  logic                last_pos;

  assign load_fire   = (state == LOAD) && bus.load_valid && !bus.abort;
  assign commit_fire = (state == COMMIT) && bus.pos_ready;
  assign last_row    = (row_cnt == ROW_BITS'(IMG_DIM - 1));
  assign last_tap    = (tap_cnt == TAP_W'(TAP_LAST));
  assign last_filt   = (filt_cnt == FILT_W'(N_FILT - 1));
  assign last_pos    = (pos_x_q == POS_W'(OUT_LAST)) && (pos_y_q == POS_W'(OUT_LAST));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_nx = state;
    if (bus.abort) begin
      state_nx = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_fire && last_row) state_nx = READY;
        READY:   if (bus.start) state_nx = RUN;
        RUN:     if (last_tap && last_filt) state_nx = COMMIT;
        COMMIT:  if (commit_fire) state_nx = last_pos ? DONE : RUN;
        DONE:    state_nx = LOAD;
        default: state_nx = LOAD;
      endcase
    end
  end

  // Row, tap, filter and window-position counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      tap_cnt  <= '0;
      filt_cnt <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
    end else if (bus.abort) begin
      row_cnt  <= '0;
      tap_cnt  <= '0;
      filt_cnt <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
    end else begin
      if (load_fire) row_cnt <= row_cnt + 1'b1;
      if (state == RUN) begin
        if (last_tap) begin
          tap_cnt  <= '0;
          filt_cnt <= last_filt ? '0 : filt_cnt + 1'b1;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
      if (commit_fire && !last_pos) begin
        if (pos_x_q == POS_W'(OUT_LAST)) begin
          pos_x_q <= '0;
          pos_y_q <= pos_y_q + 1'b1;
        end else begin
          pos_x_q <= pos_x_q + 1'b1;
        end
      end
      if (state == DONE) begin
        row_cnt <= '0;
        pos_x_q <= '0;
        pos_y_q <= '0;
      end
    end
  end

  // Window origin plus tap offset selects the image pixel
  always_comb begin
    rd_x = ROW_BITS'(32'(pos_x_q) + 32'(tap_cnt) % 32'(K_DIM));
    rd_y = ROW_BITS'(32'(pos_y_q) + 32'(tap_cnt) / 32'(K_DIM));
  end

  conv_img_buf #(
    .DIM(IMG_DIM)
  ) u_img_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (load_fire),
    .wr_addr(row_cnt),
    .wr_data(bus.load_row),
    .rd_x   (rd_x),
    .rd_y   (rd_y),
    .pixel  (pixel)
  );

  // Output decode from registered state and counters only
  always_comb begin
    bus.load_ready  = (state == LOAD);
    bus.busy        = (state == RUN) || (state == COMMIT);
    bus.tap_valid   = (state == RUN);
    bus.tap_pixel   = (state == RUN) && pixel;
    bus.weight_addr = WADDR_W'(32'(filt_cnt) * 32'(TAP_LAST + 1) + 32'(tap_cnt));
    bus.filt_idx    = filt_cnt;
    bus.acc_first   = (state == RUN) && (tap_cnt == '0);
    bus.acc_last    = (state == RUN) && last_tap;
    bus.pos_valid   = (state == COMMIT);
    bus.pos_x       = pos_x_q;
    bus.pos_y       = pos_y_q;
    bus.done        = (state == DONE);
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: load table, full-run stream model, stall, abort and reset.
module tb_conv_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_scheduler_if bus_if ();

  conv_scheduler #(
    .IMG_DIM(8),
    .K_DIM  (3),
    .N_FILT (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct packed {
    logic       lr;
    logic       busy;
    logic       tv;
    logic       px;
    logic [4:0] wa;
    logic       fi;
    logic       af;
    logic       al;
    logic       pv;
    logic [2:0] x;
    logic [2:0] y;
    logic       dn;
  } obs_t;

  typedef struct {
    logic       lv;
    logic [7:0] row;
    logic       st;
    logic       e_lr;
    logic       e_busy;
    logic       e_tv;
    logic       e_px;
    logic [4:0] e_wa;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  logic [7:0] img [8];
  vec_t       vt [15];
  obs_t       a;
  obs_t       rst_exp;

  int         done_k;
  int         done_cnt;
  int         pv0_cnt;
  int         stall_tv;
  int         quiet;
  logic [8:0] pat0;
  logic [8:0] pat1;
  logic [2:0] x_after;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.lr   = bus_if.load_ready;
    o.busy = bus_if.busy;
    o.tv   = bus_if.tap_valid;
    o.px   = bus_if.tap_pixel;
    o.wa   = bus_if.weight_addr;
    o.fi   = bus_if.filt_idx;
    o.af   = bus_if.acc_first;
    o.al   = bus_if.acc_last;
    o.pv   = bus_if.pos_valid;
    o.x    = bus_if.pos_x;
    o.y    = bus_if.pos_y;
    o.dn   = bus_if.done;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp, input obs_t mask);
    checks++;
    if (((act ^ exp) & mask) !== '0) begin
      failures++;
      $display("FAIL %s: got 0x%05h expected 0x%05h mask 0x%05h", name, act, exp, mask);
    end
  endtask

  function automatic logic exp_pix(input int p, input int t);
    logic [7:0] r;
    r = img[p / 6 + t / 3];
    return r[p % 6 + t % 3];
  endfunction

  // k = cycles after the start edge minus one; s = stall cycles at the first commit
  task automatic exp_obs(input int k, input int s, output obs_t e, output obs_t m);
    int kk;
    int p;
    int ph;
    int t;
    e = '0;
    m = '1;
    if (k >= 18 && k < 19 + s) kk = 18;
    else if (k >= 19 + s)      kk = k - s;
    else                       kk = k;
    if (kk < 684) begin
      p      = kk / 19;
      ph     = kk % 19;
      e.busy = 1'b1;
      e.x    = 3'(p % 6);
      e.y    = 3'(p / 6);
      if (ph < 18) begin
        t    = ph % 9;
        e.tv = 1'b1;
        e.px = exp_pix(p, t);
        e.wa = 5'(ph);
        e.fi = (ph >= 9);
        e.af = (t == 0);
        e.al = (t == 8);
      end else begin
        e.pv = 1'b1;
        m.px = 1'b0; m.wa = '0; m.fi = 1'b0; m.af = 1'b0; m.al = 1'b0;
      end
    end else begin
      if (kk == 684) e.dn = 1'b1;
      else           e.lr = 1'b1;
      m.px = 1'b0; m.wa = '0; m.fi = 1'b0; m.af = 1'b0; m.al = 1'b0;
      m.x  = '0;   m.y  = '0;
    end
  endtask

  task automatic run_check(input int s, input int k_first);
    obs_t ra;
    obs_t e;
    obs_t m;
    done_k   = -1;
    done_cnt = 0;
    pv0_cnt  = 0;
    stall_tv = 0;
    pat0     = '0;
    pat1     = '0;
    x_after  = '0;
    for (int k = k_first; k <= 685 + s; k++) begin
      if (k > k_first) step();
      ra = sample();
      exp_obs(k, s, e, m);
      check_obs($sformatf("stream_k%0d", k), ra, e, m);
      if (ra.dn === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (ra.pv === 1'b1 && ra.x == 3'd0 && ra.y == 3'd0) pv0_cnt++;
      if (k >= 18 && k <= 18 + s && ra.tv === 1'b1) stall_tv++;
      if (k == 19 + s) x_after = ra.x;
      if (k < 9) pat0[k] = ra.px;
      if (k >= 19 && k < 28) pat1[k - 19] = ra.px;
      bus_if.pos_ready = !(k >= 18 && k < 18 + s);
    end
    check("done_cycle", done_k, 684 + s);
    check("done_pulses", done_cnt, 1);
  endtask

  task automatic load_image();
    for (int i = 0; i < 8; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_row   = img[i];
      step();
    end
    bus_if.load_valid = 1'b0;
    check("load_complete_ready_low", 32'(bus_if.load_ready), 32'(1'b0));
  endtask

  task automatic start_run();
    bus_if.start = 1'b1;
    step();
    bus_if.start = 1'b0;
  endtask

  function automatic vec_t mk(input logic lv, input logic [7:0] row, input logic st,
                              input logic lr, input logic busy, input logic tv,
                              input logic px, input logic [4:0] wa);
    vec_t v;
    v.lv = lv; v.row = row; v.st = st;
    v.e_lr = lr; v.e_busy = busy; v.e_tv = tv; v.e_px = px; v.e_wa = wa;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    // load with gaps and an early start, then READY ignores a stray beat
    vt[0]  = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[1]  = mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[2]  = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[5]  = mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[7]  = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[8]  = mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[10] = mk(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[11] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[12] = mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[13] = mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    vt[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0);

    rst_exp    = '0;
    rst_exp.lr = 1'b1;

    rst_n             = 1'b0;
    bus_if.abort      = 1'b0;
    bus_if.load_valid = 1'b0;
    bus_if.load_row   = '0;
    bus_if.start      = 1'b0;
    bus_if.pos_ready  = 1'b1;

    // reset state
    #2;
    check_obs("reset_hold", sample(), rst_exp, '1);
    step();
    step();
    #3;
    rst_n = 1'b1;
    step();
    check_obs("reset_idle", sample(), rst_exp, '1);

    // checkerboard image via the vector table
    for (int i = 0; i < 8; i++) img[i] = (i % 2 == 0) ? 8'h55 : 8'hAA;
    for (int i = 0; i < 15; i++) begin
      bus_if.load_valid = vt[i].lv;
      bus_if.load_row   = vt[i].row;
      bus_if.start      = vt[i].st;
      step();
      a = sample();
      check($sformatf("vec%0d_ctrl", i), 32'({a.lr, a.busy, a.tv}),
            32'({vt[i].e_lr, vt[i].e_busy, vt[i].e_tv}));
      if (vt[i].e_tv) check($sformatf("vec%0d_tap", i), 32'({a.px, a.wa}), 32'({vt[i].e_px, vt[i].e_wa}));
    end
    bus_if.load_valid = 1'b0;
    bus_if.start      = 1'b0;
    run_check(0, 0);
    check("pattern_pos00", 32'(pat0), 32'(9'h155));
    check("pattern_pos10", 32'(pat1), 32'(9'h0AA));

    // all-ones image with a 5-cycle stall at the first commit
    for (int i = 0; i < 8; i++) img[i] = 8'hFF;
    load_image();
    start_run();
    run_check(5, 0);
    check("stall_pv_cycles", pv0_cnt, 6);
    check("stall_no_tap", stall_tv, 0);
    check("post_stall_pos_x", 32'(x_after), 32'(3'd1));

    // abort at position 10, tap 4, then reload and restart
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    load_image();
    start_run();
    repeat (194) step();
    a = sample();
    check("abort_point", 32'({a.x, a.y, a.wa, a.tv}), 32'({3'd4, 3'd1, 5'd4, 1'b1}));
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    a = sample();
    check("abort_state", 32'({a.lr, a.busy, a.tv, a.dn, a.pv}), 32'(5'b10000));
    quiet = 0;
    repeat (10) begin
      step();
      a = sample();
      if (a.dn !== 1'b0 || a.busy !== 1'b0 || a.tv !== 1'b0 || a.lr !== 1'b1) quiet++;
    end
    check("abort_quiet", quiet, 0);
    for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
    load_image();
    start_run();
    run_check(0, 0);

    // asynchronous reset mid-run
    load_image();
    start_run();
    repeat (40) step();
    #3;
    rst_n = 1'b0;
    #1;
    check_obs("reset_async", sample(), rst_exp, '1);
    #2;
    rst_n = 1'b1;
    step();
    a = sample();
    check("post_reset_load", 32'({a.lr, a.busy, a.tv}), 32'(3'b100));
    bus_if.start = 1'b1;
    repeat (3) step();
    bus_if.start = 1'b0;
    a = sample();
    check("start_ignored_empty", 32'({a.lr, a.busy, a.tv}), 32'(3'b100));
    for (int i = 0; i < 7; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_row   = img[i];
      step();
    end
    bus_if.load_valid = 1'b0;
    bus_if.start      = 1'b1;
    step();
    bus_if.start = 1'b0;
    a = sample();
    check("start_ignored_7rows", 32'({a.lr, a.busy, a.tv}), 32'(3'b100));
    bus_if.load_valid = 1'b1;
    bus_if.load_row   = img[7];
    step();
    bus_if.load_valid = 1'b0;
    a = sample();
    check("ready_after_8rows", 32'({a.lr, a.busy}), 32'(2'b00));
    start_run();
    a = sample();
    check("run_after_reload", 32'({a.lr, a.busy, a.tv, a.wa}), 32'({1'b0, 1'b1, 1'b1, 5'd0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
